// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a host byte stream (length header + little-endian words)
// into word writes from address 0 and holds the core in reset until the load completes.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH  = 400,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StCollect,
        StWrite,
        StDone,
        StError
`ifdef LOADER_CHECKSUM_EN
        ,
        StChk
`endif
    } state_e;

    // State taken after the last word (or an empty header).
`ifdef LOADER_CHECKSUM_EN
    localparam state_e StLast = StChk;
`else
    localparam state_e StLast = StDone;
`endif

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_q, byte_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              accept;
    logic [ADDR_W-1:0] cnt_inc;
    logic [15:0]       hdr_len;

    assign accept  = in_valid && in_ready;
    assign cnt_inc = cnt_q + ADDR_W'(1);
    assign hdr_len = {in_data, len_q[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= 16'h0000;
            cnt_q   <= '0;
            word_q  <= 32'h0000_0000;
            byte_q  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        byte_d  = byte_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (accept && (state_q != StChk)) begin
            csum_d = csum_q ^ in_data;
        end
`endif

        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StHdr0;
                    len_d   = 16'h0000;
                    cnt_d   = '0;
                    byte_d  = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            StHdr0: begin
                if (accept) begin
                    len_d   = {8'h00, in_data};
                    state_d = StHdr1;
                end
            end
            StHdr1: begin
                if (accept) begin
                    len_d = hdr_len;
                    if ({16'h0000, hdr_len} > DEPTH) begin
                        state_d = StError;
                    end else if (hdr_len == 16'h0000) begin
                        state_d = StLast;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (accept) begin
                    // First byte of a word ends up in [7:0] after four shifts.
                    word_d = {in_data, word_q[31:8]};
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                cnt_d = cnt_inc;
                if (cnt_inc == ADDR_W'(len_q)) begin
                    state_d = StLast;
                end else begin
                    state_d = StCollect;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? StDone : StError;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StCollect);
`ifdef LOADER_CHECKSUM_EN
        if (state_q == StChk) begin
            in_ready = 1'b1;
        end
`endif
        wr_en    = (state_q == StWrite);
        wr_addr  = cnt_q;
        wr_data  = word_q;
        busy     = in_ready || wr_en;
        done     = (state_q == StDone);
        error    = (state_q == StError);
        cpu_hold = (state_q != StDone);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as streams are driven and
// popped by a write monitor; each scenario task checks status outputs inline.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_e;
    logic [7:0]  stream[$];

    imem_loader #(.DEPTH(400), .ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%08h", wr_addr, wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== exp_e) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%08h want addr=%0d data=%08h",
                             wr_addr, wr_data, exp_e[63:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout byte=%02h in_ready=%b want 1", b, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_stream(input int gap, input bit add_csum);
        logic [7:0] x = 8'h00;
        foreach (stream[i]) begin
            x ^= stream[i];
            send_byte(stream[i], gap);
        end
`ifdef LOADER_CHECKSUM_EN
        if (add_csum) send_byte(x, gap);
`endif
        stream.delete();
    endtask

    task automatic basic_payload();
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_q.push_back({32'd0, 32'h0000_0013});
        exp_q.push_back({32'd1, 32'h0010_0093});
    endtask

    task automatic wait_end(input string name, input logic exp_done, input logic exp_err,
                            input int exp_writes, input int wr_base);
        int n = 0;
        while (!(done || error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({done, error, cpu_hold, busy} !== {exp_done, exp_err, !exp_done, 1'b0}) begin
            failures++;
            $display("FAIL %s_status done/err/hold/busy=%b%b%b%b want %b%b%b0", name, done,
                     error, cpu_hold, busy, exp_done, exp_err, !exp_done);
        end
        checks++;
        if ((wr_count - wr_base) !== exp_writes || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_writes got=%0d want=%0d pending=%0d", name, wr_count - wr_base,
                     exp_writes, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if ({in_ready, wr_en, busy, done, error, cpu_hold} !== 6'b000001 ||
            wr_addr !== 32'd0 || wr_data !== 32'd0) begin
            failures++;
            $display("FAIL %s rdy/wr/busy/done/err/hold=%b%b%b%b%b%b addr=%0d data=%08h want 000001 0 0",
                     name, in_ready, wr_en, busy, done, error, cpu_hold, wr_addr, wr_data);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("idle_after_reset");
    endtask

    task automatic test_basic();
        int base = wr_count;
        pulse_start();
        checks++;
        if ({busy, in_ready, cpu_hold} !== 3'b111) begin
            failures++;
            $display("FAIL hdr0_status busy/rdy/hold=%b%b%b want 111", busy, in_ready, cpu_hold);
        end
        basic_payload();
        send_stream(0, 1'b1);
        wait_end("basic", 1'b1, 1'b0, 2, base);
    endtask

    task automatic test_stall();
        int base = wr_count;
        pulse_start();
        checks++;
        if ({done, cpu_hold} !== 2'b01) begin
            failures++;
            $display("FAIL restart_status done/hold=%b%b want 01", done, cpu_hold);
        end
        basic_payload();
        send_stream(3, 1'b1);
        repeat (5) @(negedge clk);
        wait_end("stall", 1'b1, 1'b0, 2, base);
    endtask

    task automatic test_oversize();
        int base = wr_count;
        pulse_start();
        stream = '{8'h91, 8'h01};
        send_stream(0, 1'b0);
        wait_end("oversize", 1'b0, 1'b1, 0, base);
        base = wr_count;
        pulse_start();
        basic_payload();
        send_stream(0, 1'b1);
        wait_end("after_oversize", 1'b1, 1'b0, 2, base);
    endtask

    task automatic test_reset_mid();
        int base = wr_count;
        pulse_start();
        stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.push_back({32'd0, 32'h4433_2211});
        send_stream(0, 1'b0);
        rst = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        checks++;
        if ((wr_count - base) !== 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_writes got=%0d want=1", wr_count - base);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("after_mid_reset");
    endtask

    task automatic test_zero_len();
        int base = wr_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        checks++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            failures++;
            $display("FAIL zero_len done/err/hold=%b%b%b want 100", done, error, cpu_hold);
        end
        wait_end("zero_len", 1'b1, 1'b0, 0, base);
    endtask

    task automatic test_ignored_start();
        int base = wr_count;
        pulse_start();
        stream = '{8'h02, 8'h00, 8'hEF, 8'hBE};
        send_stream(0, 1'b0);
        pulse_start();
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL start_in_collect busy/rdy=%b%b want 11", busy, in_ready);
        end
        stream = '{8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        exp_q.push_back({32'd0, 32'hDEAD_BEEF});
        exp_q.push_back({32'd1, 32'h1234_5678});
        // Checksum must still cover the header and first two bytes already sent.
`ifdef LOADER_CHECKSUM_EN
        foreach (stream[i]) send_byte(stream[i], 0);
        send_byte(8'h02 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12, 0);
        stream.delete();
`else
        send_stream(0, 1'b0);
`endif
        wait_end("ignored_start", 1'b1, 1'b0, 2, base);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int base = wr_count;
        pulse_start();
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        exp_q.push_back({32'd0, 32'h0000_0013});
        send_stream(0, 1'b0);
        wait_end("csum_good", 1'b1, 1'b0, 1, base);
        base = wr_count;
        pulse_start();
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back({32'd0, 32'h0000_0013});
        send_stream(0, 1'b0);
        wait_end("csum_bad", 1'b0, 1'b1, 1, base);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_oversize();
        test_reset_mid();
        test_zero_len();
        test_ignored_start();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
